// File: rtl/alu_arbiter_if.sv
// Request/response bundle shared by the ALU arbiter and its requesters/consumer.
// Latency: none (wires only).
// Backpressure: valid/ready on both request ports and on the response bus.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_aluc;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_aluc;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_r;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_negative;
    logic        rsp_overflow;
    logic        busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_aluc,
        input  req1_valid, req1_a, req1_b, req1_aluc,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_carry, rsp_negative, rsp_overflow,
        output busy
    );

    // Requester / consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_aluc,
        output req1_valid, req1_a, req1_b, req1_aluc,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_carry, rsp_negative, rsp_overflow,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one 32-bit ALU; result + flags land in a single output slot.
// Latency: 1 cycle from accept to rsp_valid; 1 result/cycle when the slot drains and refills together.
// Backpressure: a full slot with rsp_ready low holds all rsp_* stable and drops both req*_ready.
module alu_arbiter #(
    parameter int PRIO_MODE = 0,   // 0 = round-robin, 1 = fixed priority to port 0
    parameter int MAX_WAIT  = 8    // port-1 starvation limit in fixed-priority mode (1..255)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic        slot_valid;
    logic        slot_id;
    logic [31:0] slot_r;
    logic        slot_zero, slot_carry, slot_negative, slot_overflow;
    logic        rr_ptr;
    logic [7:0]  wait_cnt;

    logic        slot_free;
    logic        prio1;
    logic        grant0, grant1;
    logic        acc0, acc1, accept;

    logic [31:0] op_a, op_b;
    logic [3:0]  op_c;
    logic [4:0]  sh;
    logic [32:0] sum_ext, diff_ext, shr_ext, shl_ext;
    logic [31:0] alu_r;
    logic        alu_carry, alu_overflow;

    // A consumer taking the current result frees the slot in the same cycle.
    assign slot_free = ~slot_valid | bus.rsp_ready;

    // Port 1 wins a contested cycle when it holds the round-robin turn, or when
    // it has starved for MAX_WAIT cycles under fixed priority.
    assign prio1  = (PRIO_MODE == 0) ? rr_ptr : (wait_cnt == MAX_W);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | prio1);
    assign grant0 = bus.req0_valid & ~grant1;

    // rst_n gating keeps ready low for the whole time reset is asserted.
    assign acc0   = grant0 & slot_free & rst_n;
    assign acc1   = grant1 & slot_free & rst_n;
    assign accept = acc0 | acc1;

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;

    // Operand mux follows the grant, not the accept, so the ALU output is
    // meaningful even while the slot is blocked.
    assign op_a = grant1 ? bus.req1_a    : bus.req0_a;
    assign op_b = grant1 ? bus.req1_b    : bus.req0_b;
    assign op_c = grant1 ? bus.req1_aluc : bus.req0_aluc;
    assign sh   = op_a[4:0];

    // Extended forms: bit 32 of sum/diff is carry/borrow; bit 0 of shr_ext and
    // bit 32 of shl_ext are the last bit shifted out (0 for a zero shift).
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
    assign shr_ext  = {op_b, 1'b0} >> sh;
    assign shl_ext  = {1'b0, op_b} << sh;

    // ALU datapath: result, carry (addu/subu/sltu/shifts) and overflow (add/sub).
    always_comb begin
        alu_r        = 32'h0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (op_c)
            4'b0000: begin alu_r = sum_ext[31:0];  alu_carry = sum_ext[32];  end
            4'b0010: begin
                alu_r        = sum_ext[31:0];
                alu_overflow = (op_a[31] == op_b[31]) && (sum_ext[31] != op_a[31]);
            end
            4'b0001: begin alu_r = diff_ext[31:0]; alu_carry = diff_ext[32]; end
            4'b0011: begin
                alu_r        = diff_ext[31:0];
                alu_overflow = (op_a[31] != op_b[31]) && (diff_ext[31] != op_a[31]);
            end
            4'b0100: alu_r = op_a & op_b;
            4'b0101: alu_r = op_a | op_b;
            4'b0110: alu_r = op_a ^ op_b;
            4'b0111: alu_r = ~(op_a | op_b);
            4'b1000: alu_r = {op_b[15:0], 16'h0};
            4'b1001: alu_r = op_a;
            4'b1011: alu_r = {31'h0, $signed(op_a) < $signed(op_b)};
            4'b1010: begin alu_r = {31'h0, diff_ext[32]}; alu_carry = diff_ext[32]; end
            4'b1100: begin alu_r = $unsigned($signed(op_b) >>> sh); alu_carry = shr_ext[0]; end
            4'b1101: begin alu_r = shr_ext[32:1]; alu_carry = shr_ext[0]; end
            default: begin alu_r = shl_ext[31:0]; alu_carry = shl_ext[32]; end
        endcase
    end

    // Output slot and round-robin pointer: load on accept, empty on a drain with no refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid    <= 1'b0;
            slot_id       <= 1'b0;
            slot_r        <= 32'h0;
            slot_zero     <= 1'b0;
            slot_carry    <= 1'b0;
            slot_negative <= 1'b0;
            slot_overflow <= 1'b0;
            rr_ptr        <= 1'b0;
        end else if (accept) begin
            slot_valid    <= 1'b1;
            slot_id       <= acc1;
            slot_r        <= alu_r;
            slot_zero     <= (alu_r == 32'h0);
            slot_carry    <= alu_carry;
            slot_negative <= alu_r[31];
            slot_overflow <= alu_overflow;
            rr_ptr        <= ~acc1;
        end else if (bus.rsp_ready) begin
            slot_valid    <= 1'b0;
        end
    end

    // Starvation counter: counts every cycle port 1 waits (including slot stalls), saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'h0;
        end else if ((PRIO_MODE == 0) || !bus.req1_valid || acc1) begin
            wait_cnt <= 8'h0;
        end else if (wait_cnt != MAX_W) begin
            wait_cnt <= wait_cnt + 8'h1;
        end
    end

    assign bus.rsp_valid    = slot_valid;
    assign bus.rsp_id       = slot_id;
    assign bus.rsp_r        = slot_r;
    assign bus.rsp_zero     = slot_zero;
    assign bus.rsp_carry    = slot_carry;
    assign bus.rsp_negative = slot_negative;
    assign bus.rsp_overflow = slot_overflow;
    assign bus.busy         = slot_valid | bus.req0_valid | bus.req1_valid;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: checks results one cycle after accept.
// Backpressure: exercises stalled slot, simultaneous drain/refill and starvation timeout.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if if_rr();
    alu_arbiter_if if_fp();

    alu_arbiter #(.PRIO_MODE(0), .MAX_WAIT(8)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));
    alu_arbiter #(.PRIO_MODE(1), .MAX_WAIT(3)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));

    int checks = 0;
    int errors = 0;

    // Reference state for the round-robin instance
    logic        m_valid;
    logic        m_id;
    logic [35:0] m_res;
    logic        m_rr;
    logic        pend [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [3:0]  pc [2];

    // Reference ALU: {result, zero, carry, negative, overflow}
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        longint ua, ub, sa, sb, t;
        int sh;
        logic [31:0] r;
        logic cy, ov;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sh = int'(a[4:0]);
        r = 32'h0; cy = 1'b0; ov = 1'b0;
        case (c)
            4'b0000: begin t = ua + ub; r = t[31:0]; cy = (t >= 64'd4294967296); end
            4'b0010: begin t = sa + sb; r = t[31:0]; ov = (t != longint'($signed(r))); end
            4'b0001: begin r = a - b; cy = (ua < ub); end
            4'b0011: begin t = sa - sb; r = t[31:0]; ov = (t != longint'($signed(r))); end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1000: r = b << 16;
            4'b1001: r = a;
            4'b1011: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1010: begin r = (ua < ub) ? 32'd1 : 32'd0; cy = (ua < ub); end
            4'b1100: begin t = sb >>> sh; r = t[31:0]; cy = (sh != 0) && b[sh-1]; end
            4'b1101: begin t = ub >> sh;  r = t[31:0]; cy = (sh != 0) && b[sh-1]; end
            default: begin t = ub << sh;  r = t[31:0]; cy = (sh != 0) && b[32-sh]; end
        endcase
        return {r, (r == 32'h0), cy, r[31], ov};
    endfunction

    // Port the round-robin instance should grant this cycle (-1 = none)
    function automatic int exp_grant();
        if (if_rr.req0_valid && if_rr.req1_valid) return m_rr ? 1 : 0;
        if (if_rr.req0_valid) return 0;
        if (if_rr.req1_valid) return 1;
        return -1;
    endfunction

    // Advance one clock and the round-robin model with it; returns at the falling edge.
    task automatic tick();
        int g;
        logic sf;
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_id = 1'b0; m_res = '0; m_rr = 1'b0;
        end else begin
            g = exp_grant();
            sf = !m_valid || if_rr.rsp_ready;
            if (g >= 0 && sf) begin
                m_valid = 1'b1;
                m_id = g[0];
                m_res = (g == 1) ? alu_ref(if_rr.req1_a, if_rr.req1_b, if_rr.req1_aluc)
                                 : alu_ref(if_rr.req0_a, if_rr.req0_b, if_rr.req0_aluc);
                m_rr = (g == 0);
                pend[g] = 1'b0;
            end else if (if_rr.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        if_rr.req0_valid = 0; if_rr.req0_a = 0; if_rr.req0_b = 0; if_rr.req0_aluc = 0;
        if_rr.req1_valid = 0; if_rr.req1_a = 0; if_rr.req1_b = 0; if_rr.req1_aluc = 0;
        if_rr.rsp_ready = 0;
        if_fp.req0_valid = 0; if_fp.req0_a = 0; if_fp.req0_b = 0; if_fp.req0_aluc = 0;
        if_fp.req1_valid = 0; if_fp.req1_a = 0; if_fp.req1_b = 0; if_fp.req1_aluc = 0;
        if_fp.rsp_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        if_rr.req0_valid = 1; if_rr.req1_valid = 1; if_fp.req0_valid = 1; if_fp.req1_valid = 1;
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", if_rr.rsp_valid); end
        checks++; if (if_rr.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", if_rr.rsp_id); end
        checks++; if (if_rr.rsp_r !== 32'h0) begin errors++; $display("FAIL reset_rsp_r got %h want 0", if_rr.rsp_r); end
        checks++; if ({if_rr.rsp_zero, if_rr.rsp_carry, if_rr.rsp_negative, if_rr.rsp_overflow} !== 4'b0)
            begin errors++; $display("FAIL reset_flags got %b want 0000", {if_rr.rsp_zero, if_rr.rsp_carry, if_rr.rsp_negative, if_rr.rsp_overflow}); end
        checks++; if ({if_rr.req0_ready, if_rr.req1_ready, if_fp.req0_ready, if_fp.req1_ready} !== 4'b0)
            begin errors++; $display("FAIL reset_ready got %b want 0000", {if_rr.req0_ready, if_rr.req1_ready, if_fp.req0_ready, if_fp.req1_ready}); end
        idle_all();
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        if_rr.req0_a = 32'hFFFFFFFF; if_rr.req0_b = 32'h1; if_rr.req0_aluc = 4'b0000;
        if_rr.req0_valid = 1; if_rr.rsp_ready = 1;
        #1;
        checks++; if (if_rr.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", if_rr.req0_ready); end
        tick();
        if_rr.req0_valid = 0; if_rr.rsp_ready = 0;
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", if_rr.rsp_valid); end
        checks++; if (if_rr.rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", if_rr.rsp_id); end
        checks++; if (if_rr.rsp_r !== 32'h0) begin errors++; $display("FAIL single_r got %h want 0", if_rr.rsp_r); end
        checks++; if ({if_rr.rsp_zero, if_rr.rsp_carry, if_rr.rsp_overflow} !== 3'b110)
            begin errors++; $display("FAIL single_flags zco got %b want 110", {if_rr.rsp_zero, if_rr.rsp_carry, if_rr.rsp_overflow}); end
        #1 rst_n = 1'b0;
        m_valid = 1'b0; m_id = 1'b0; m_res = '0; m_rr = 1'b0;
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", if_rr.rsp_valid); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_backpressure();
        if_rr.rsp_ready = 0;
        if_rr.req1_a = 32'h80000000; if_rr.req1_b = 32'h1; if_rr.req1_aluc = 4'b0011; if_rr.req1_valid = 1;
        #1;
        checks++; if (if_rr.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_ready got %b want 1", if_rr.req1_ready); end
        tick();
        if_rr.req1_valid = 0;
        if_rr.req0_a = 32'd5; if_rr.req0_b = 32'd6; if_rr.req0_aluc = 4'b0000; if_rr.req0_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_rr.rsp_valid !== 1'b1 || if_rr.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_hold_vid got %b%b want 11", if_rr.rsp_valid, if_rr.rsp_id); end
            checks++; if (if_rr.rsp_r !== 32'h7FFFFFFF || if_rr.rsp_overflow !== 1'b1) begin errors++; $display("FAIL bp_hold_r got %h/%b want 7fffffff/1", if_rr.rsp_r, if_rr.rsp_overflow); end
            checks++; if (if_rr.req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_blocked got %b want 0", if_rr.req0_ready); end
            tick();
        end
        if_rr.rsp_ready = 1;
        #1;
        checks++; if (if_rr.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_accept got %b want 1", if_rr.req0_ready); end
        tick();
        if_rr.req0_valid = 0;
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b1 || if_rr.rsp_id !== 1'b0 || if_rr.rsp_r !== 32'd11)
            begin errors++; $display("FAIL bp_after_drain got v=%b id=%b r=%h want 1 0 0000000b", if_rr.rsp_valid, if_rr.rsp_id, if_rr.rsp_r); end
        tick();
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", if_rr.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic exp_id;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_rr.req0_a = $urandom; if_rr.req0_b = 32'h1234; if_rr.req0_aluc = 4'b1000; if_rr.req0_valid = 1;
        if_rr.req1_a = 32'hFFFFFFFF; if_rr.req1_b = 32'h1; if_rr.req1_aluc = 4'b1011; if_rr.req1_valid = 1;
        if_rr.rsp_ready = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            exp_id = (i % 2 == 0) ? 1'b0 : 1'b1;
            #1;
            checks++; if (if_rr.rsp_valid !== 1'b1 || if_rr.rsp_id !== exp_id)
                begin errors++; $display("FAIL rr_seq[%0d] got v=%b id=%b want 1 %b", i, if_rr.rsp_valid, if_rr.rsp_id, exp_id); end
            checks++; if (if_rr.rsp_r !== (exp_id ? 32'h1 : 32'h12340000))
                begin errors++; $display("FAIL rr_r[%0d] got %h want %h", i, if_rr.rsp_r, (exp_id ? 32'h1 : 32'h12340000)); end
            tick();
        end
        if_rr.req0_valid = 0; if_rr.req1_valid = 0;
        tick();
        if_rr.rsp_ready = 0;
    endtask

    task automatic test_fixed_prio();
        logic exp_id;
        logic [31:0] exp_r;
        if_fp.req0_a = $urandom; if_fp.req0_b = $urandom; if_fp.req0_aluc = 4'b0100; if_fp.req0_valid = 1;
        if_fp.req1_a = $urandom; if_fp.req1_b = $urandom; if_fp.req1_aluc = 4'b0101; if_fp.req1_valid = 1;
        if_fp.rsp_ready = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
            exp_id = (i % 4 == 3);
            exp_r = exp_id ? (if_fp.req1_a | if_fp.req1_b) : (if_fp.req0_a & if_fp.req0_b);
            checks++; if (if_fp.rsp_id !== exp_id) begin errors++; $display("FAIL fp_seq[%0d] got %b want %b", i, if_fp.rsp_id, exp_id); end
            checks++; if (if_fp.rsp_r !== exp_r) begin errors++; $display("FAIL fp_r[%0d] got %h want %h", i, if_fp.rsp_r, exp_r); end
        end
        // Starvation keeps counting while the slot is stalled
        if_fp.rsp_ready = 0;
        repeat (5) tick();
        if_fp.rsp_ready = 1;
        #1;
        checks++; if ({if_fp.req0_ready, if_fp.req1_ready} !== 2'b01)
            begin errors++; $display("FAIL fp_stall_timeout got r0r1=%b want 01", {if_fp.req0_ready, if_fp.req1_ready}); end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++; if (if_fp.rsp_id !== 1'b0) begin errors++; $display("FAIL fp_post_timeout[%0d] got %b want 0", i, if_fp.rsp_id); end
        end
        if_fp.req0_valid = 0; if_fp.req1_valid = 0;
        tick(); tick();
        if_fp.rsp_ready = 0;
    endtask

    task automatic test_back_to_back();
        if_rr.rsp_ready = 1;
        if_rr.req0_a = 32'hF0F0F0F0; if_rr.req0_b = 32'h0FF00FF0; if_rr.req0_aluc = 4'b0100; if_rr.req0_valid = 1;
        #1;
        checks++; if (if_rr.req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", if_rr.req0_ready); end
        tick();
        if_rr.req0_a = 32'd31; if_rr.req0_b = 32'h80000000; if_rr.req0_aluc = 4'b1101;
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b1 || if_rr.rsp_r !== 32'h00F000F0)
            begin errors++; $display("FAIL b2b_first got v=%b r=%h want 1 00f000f0", if_rr.rsp_valid, if_rr.rsp_r); end
        checks++; if (if_rr.req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", if_rr.req0_ready); end
        tick();
        if_rr.req0_valid = 0;
        #1;
        checks++; if (if_rr.rsp_valid !== 1'b1 || if_rr.rsp_r !== 32'h1 || if_rr.rsp_carry !== 1'b0)
            begin errors++; $display("FAIL b2b_second got v=%b r=%h c=%b want 1 00000001 0", if_rr.rsp_valid, if_rr.rsp_r, if_rr.rsp_carry); end
        tick();
        if_rr.rsp_ready = 0;
    endtask

    task automatic test_idle_busy();
        tick();
        #1;
        checks++; if ({if_rr.busy, if_rr.rsp_valid, if_rr.req0_ready, if_rr.req1_ready} !== 4'b0)
            begin errors++; $display("FAIL idle got busy/v/r0/r1=%b want 0000", {if_rr.busy, if_rr.rsp_valid, if_rr.req0_ready, if_rr.req1_ready}); end
        if_rr.req1_a = 32'd3; if_rr.req1_b = 32'd4; if_rr.req1_aluc = 4'b0000; if_rr.req1_valid = 1;
        #1;
        checks++; if (if_rr.busy !== 1'b1 || if_rr.req1_ready !== 1'b1)
            begin errors++; $display("FAIL busy_req got busy=%b r1=%b want 1 1", if_rr.busy, if_rr.req1_ready); end
        tick();
        if_rr.req1_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (if_rr.busy !== 1'b1) begin errors++; $display("FAIL busy_hold[%0d] got %b want 1", i, if_rr.busy); end
            tick();
        end
        if_rr.rsp_ready = 1;
        #1;
        checks++; if (if_rr.busy !== 1'b1) begin errors++; $display("FAIL busy_drain got %b want 1", if_rr.busy); end
        tick();
        #1;
        checks++; if (if_rr.busy !== 1'b0) begin errors++; $display("FAIL busy_after got %b want 0", if_rr.busy); end
        if_rr.rsp_ready = 0;
    endtask

    task automatic test_random();
        logic [31:0] corner [4];
        int g;
        logic sf;
        corner[0] = 32'h0; corner[1] = 32'h7FFFFFFF; corner[2] = 32'h80000000; corner[3] = 32'hFFFFFFFF;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom % 2 == 1)) begin
                    pend[p] = 1'b1;
                    pa[p] = ($urandom % 4 == 0) ? corner[$urandom % 4] : $urandom;
                    pb[p] = ($urandom % 4 == 0) ? corner[$urandom % 4] : $urandom;
                    pc[p] = 4'($urandom);
                end
            end
            if_rr.req0_valid = pend[0]; if_rr.req0_a = pa[0]; if_rr.req0_b = pb[0]; if_rr.req0_aluc = pc[0];
            if_rr.req1_valid = pend[1]; if_rr.req1_a = pa[1]; if_rr.req1_b = pb[1]; if_rr.req1_aluc = pc[1];
            if_rr.rsp_ready = ($urandom % 4 != 0);
            #1;
            g = exp_grant();
            sf = !m_valid || if_rr.rsp_ready;
            checks++; if ({if_rr.req0_ready, if_rr.req1_ready} !== {(g == 0) && sf, (g == 1) && sf})
                begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", cyc, {if_rr.req0_ready, if_rr.req1_ready}, {(g == 0) && sf, (g == 1) && sf}); end
            checks++; if (if_rr.rsp_valid !== m_valid || if_rr.busy !== (m_valid | pend[0] | pend[1]))
                begin errors++; $display("FAIL rand_valid_busy[%0d] got %b%b want %b%b", cyc, if_rr.rsp_valid, if_rr.busy, m_valid, m_valid | pend[0] | pend[1]); end
            if (m_valid) begin
                checks++;
                if ({if_rr.rsp_id, if_rr.rsp_r, if_rr.rsp_zero, if_rr.rsp_carry, if_rr.rsp_negative, if_rr.rsp_overflow} !== {m_id, m_res})
                    begin errors++; $display("FAIL rand_rsp[%0d] got id=%b r=%h zcno=%b want id=%b r=%h zcno=%b", cyc, if_rr.rsp_id, if_rr.rsp_r,
                        {if_rr.rsp_zero, if_rr.rsp_carry, if_rr.rsp_negative, if_rr.rsp_overflow}, m_id, m_res[35:4], m_res[3:0]); end
            end
            tick();
        end
        if_rr.req0_valid = 0; if_rr.req1_valid = 0; if_rr.rsp_ready = 1;
        tick();
        if_rr.rsp_ready = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        m_valid = 1'b0; m_id = 1'b0; m_res = '0; m_rr = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        idle_all();
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_fixed_prio();
        test_back_to_back();
        test_idle_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
